// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache.
// - State encoding for the cache controller FSM.
// - Line/word/address widths used by the interface, array and top.
// - line_word(): selects one 32-bit word out of a 128-bit line.
package dcache_pkg;

  localparam int LINE_W     = 128;
  localparam int WORD_W     = 32;
  localparam int ADDR_W     = 30;
  localparam int MEM_ADDR_W = 28;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_ALLOCATE  = 2'd2
  } state_t;

  // Word 0 lives in bits [31:0] of a line.
  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                  input logic [1:0]        sel);
    return line[{sel, 5'd0} +: WORD_W];
  endfunction

endpackage

// File: rtl/dcache_dm_wb_if.sv
// Bus bundle between the pipeline, the cache and the memory model.
// Processor side: proc_ren/proc_wen/proc_addr/proc_wdata in, proc_stall/proc_rdata out.
// Memory side: mem_read/mem_write/mem_addr/mem_wdata out, mem_rdata/mem_ready in.
// Handshake: a request is any cycle with proc_ren|proc_wen; the requester holds every
// proc_* signal stable while proc_stall is high, and the request completes in the first
// cycle with proc_stall low. On the memory side mem_read/mem_write plus mem_addr/mem_wdata
// stay stable until the one-cycle mem_ready pulse that completes the transfer.
// Modports: slave = the cache, master = the pipeline plus memory model.
interface dcache_dm_wb_if;
  import dcache_pkg::*;

  logic                  proc_ren;
  logic                  proc_wen;
  logic [ADDR_W-1:0]     proc_addr;
  logic [WORD_W-1:0]     proc_wdata;
  logic                  proc_stall;
  logic [WORD_W-1:0]     proc_rdata;

  logic                  mem_read;
  logic                  mem_write;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0]     mem_wdata;
  logic [LINE_W-1:0]     mem_rdata;
  logic                  mem_ready;

  modport slave (
    input  proc_ren, proc_wen, proc_addr, proc_wdata, mem_rdata, mem_ready,
    output proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output proc_ren, proc_wen, proc_addr, proc_wdata, mem_rdata, mem_ready,
    input  proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
  );

endinterface

// File: rtl/dcache_array.sv
// Storage for the direct-mapped cache: valid/dirty bits, tags and line data.
// Ports:
//   i_clk, rst           clock, async active-high reset (clears valid/dirty only)
//   idx                  line index for the read port and both write ports
//   rd_valid/rd_dirty/rd_tag/rd_line   combinational read of the indexed line
//   word_we/word_sel/word_data         write one word, marks the line dirty
//   fill_en/fill_tag/fill_line         write a whole line, valid=1, dirty=0
module dcache_array
  import dcache_pkg::*;
#(
  parameter int INDEX_W = 3
) (
  input  logic                          i_clk,
  input  logic                          rst,
  input  logic [INDEX_W-1:0]            idx,
  output logic                          rd_valid,
  output logic                          rd_dirty,
  output logic [MEM_ADDR_W-INDEX_W-1:0] rd_tag,
  output logic [LINE_W-1:0]             rd_line,
  input  logic                          word_we,
  input  logic [1:0]                    word_sel,
  input  logic [WORD_W-1:0]             word_data,
  input  logic                          fill_en,
  input  logic [MEM_ADDR_W-INDEX_W-1:0] fill_tag,
  input  logic [LINE_W-1:0]             fill_line
);

  localparam int NLINES = 1 << INDEX_W;
  localparam int TAG_W  = MEM_ADDR_W - INDEX_W;

  logic [NLINES-1:0] valid_q;
  logic [NLINES-1:0] dirty_q;
  logic [TAG_W-1:0]  tag_q  [NLINES];
  logic [LINE_W-1:0] data_q [NLINES];

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (word_we) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // Tags and data are meaningless while valid is clear, so they carry no reset.
  always_ff @(posedge i_clk) begin
    if (fill_en) begin
      tag_q[idx]  <= fill_tag;
      data_q[idx] <= fill_line;
    end else if (word_we) begin
      data_q[idx][{word_sel, 5'd0} +: WORD_W] <= word_data;
    end
  end

  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_line  = data_q[idx];

endmodule

// File: rtl/dcache_dm_wb.sv
// Direct-mapped, write-back, write-allocate data cache with 4-word lines.
// Ports:
//   i_clk, rst     clock and asynchronous active-high reset
//   bus            dcache_dm_wb_if.slave (processor request port + 128-bit memory port)
//   dbg_state      current controller state
//   hit_cnt, miss_cnt  performance counters, present only with DCACHE_PERF_EN defined
// Optional feature macro: DCACHE_PERF_EN.
// Address split: [1:0] word in line, [INDEX_W+1:2] index, [29:INDEX_W+2] tag.
module dcache_dm_wb
  import dcache_pkg::*;
#(
  parameter int INDEX_W = 3
) (
  input  logic          i_clk,
  input  logic          rst,
  dcache_dm_wb_if.slave bus,
  output state_t        dbg_state
`ifdef DCACHE_PERF_EN
  ,
  output logic [31:0]   hit_cnt,
  output logic [31:0]   miss_cnt
`endif
);

  localparam int TAG_W = MEM_ADDR_W - INDEX_W;

  state_t             state_q, state_d;
  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic [1:0]         wsel;
  logic               rd_valid, rd_dirty;
  logic [TAG_W-1:0]   rd_tag;
  logic [LINE_W-1:0]  rd_line;
  logic               req, hit, word_we, fill_en;

  // The cache never latches the request; it relies on the CPU holding proc_* during a stall.
  assign idx  = bus.proc_addr[INDEX_W+1:2];
  assign tag  = bus.proc_addr[ADDR_W-1:INDEX_W+2];
  assign wsel = bus.proc_addr[1:0];
  assign req  = bus.proc_ren | bus.proc_wen;
  assign hit  = rd_valid && (rd_tag == tag);

  dcache_array #(.INDEX_W(INDEX_W)) u_array (
    .i_clk     (i_clk),
    .rst       (rst),
    .idx       (idx),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line),
    .word_we   (word_we),
    .word_sel  (wsel),
    .word_data (bus.proc_wdata),
    .fill_en   (fill_en),
    .fill_tag  (tag),
    .fill_line (bus.mem_rdata)
  );

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    bus.proc_stall = 1'b0;
    bus.proc_rdata = '0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    word_we        = 1'b0;
    fill_en        = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.proc_rdata = line_word(rd_line, wsel);
        if (req) begin
          if (hit) begin
            // proc_wen wins when both strobes are high.
            word_we = bus.proc_wen;
          end else begin
            bus.proc_stall = 1'b1;
            state_d = (rd_valid && rd_dirty) ? S_WRITEBACK : S_ALLOCATE;
          end
        end
      end
      S_WRITEBACK: begin
        bus.proc_stall = req;
        bus.mem_write  = 1'b1;
        bus.mem_addr   = {rd_tag, idx};
        bus.mem_wdata  = rd_line;
        if (bus.mem_ready) state_d = S_ALLOCATE;
      end
      S_ALLOCATE: begin
        bus.proc_stall = req;
        bus.mem_read   = 1'b1;
        bus.mem_addr   = bus.proc_addr[ADDR_W-1:2];
        if (bus.mem_ready) begin
          fill_en = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dbg_state = state_q;

`ifdef DCACHE_PERF_EN
  // refill_q marks the IDLE cycle right after a fill so the retried request is not
  // counted as a hit on top of the miss already recorded for it.
  logic refill_q;

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      refill_q <= 1'b0;
    end else if (state_q == S_IDLE) begin
      refill_q <= 1'b0;
      if (req && hit && !refill_q) hit_cnt <= hit_cnt + 32'd1;
      if (req && !hit) miss_cnt <= miss_cnt + 32'd1;
    end else if (state_q == S_ALLOCATE && bus.mem_ready) begin
      refill_q <= 1'b1;
    end
  end
`endif

endmodule
